l2_cache: RTL and testbench
===========================

Name: l2_cache

Overview:
- Unified direct-mapped, write-back L2 cache that sits directly downstream of the L1 cache. It serves L1 line fills and L1 dirty-line writebacks.
- Both interfaces carry whole 128-bit lines with 28-bit line addresses (byte address bits [31:4]).
- Misses go to main memory through an identical request/ready handshake.
- Exposes saturating access and miss counters for performance measurement.

Parameters:
- INDEX_W, 6: line index width; the cache holds 2^INDEX_W lines.
- TAG_W, 22: tag width; must equal 28-INDEX_W.
- LINE_W, 128: line width in bits (4 words).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- proc_read  in  1  L1 line-fill request; held until proc_ready
- proc_write  in  1  L1 line-writeback request; held until proc_ready
- proc_addr  in  28  line address (tag = [27:INDEX_W], index = [INDEX_W-1:0])
- proc_wdata  in  128  writeback line
- proc_rdata  out  128  fill line; valid while proc_ready=1, held afterwards
- proc_ready  out  1  one-cycle completion pulse
- mem_read  out  1  memory line read
- mem_write  out  1  memory line write
- mem_addr  out  28  memory line address
- mem_wdata  out  128  memory write line
- mem_rdata  in  128  memory read line
- mem_ready  in  1  memory completion pulse
- access_cnt  out  16  accepted requests, saturates at 16'hFFFF
- miss_cnt  out  16  misses, saturates at 16'hFFFF

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low. Reset clears all outputs, all valid/dirty bits and tags, both counters and the state (to IDLE). Line data arrays need not be reset.
- Reset mid-operation: outputs drop immediately and any memory transaction is abandoned.
- All outputs are registered.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND.
- IDLE:
  - On proc_read|proc_write: latch proc_addr, proc_wdata and the operation, increment access_cnt, go to COMPARE.
  - If both proc_read and proc_write are high, the write wins.
- COMPARE, hit (valid and tag match):
  - Read: proc_rdata <= line.
  - Write: line <= latched wdata, dirty <= 1.
  - Go to RESPOND.
- COMPARE, miss: increment miss_cnt.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise, read: go to ALLOCATE.
  - Otherwise, write: install the latched line directly (tag, valid=1, dirty=1) and go to RESPOND. No fetch is needed because the whole line is overwritten.
- WRITEBACK:
  - mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line.
  - Signals held stable until mem_ready is sampled high. mem_write drops in the following cycle.
  - Then clear the victim's dirty bit. A read goes to ALLOCATE; a write goes back to COMPARE and takes the no-fetch install path.
- ALLOCATE:
  - mem_read=1, mem_addr=latched proc_addr, held until mem_ready.
  - On mem_ready: line <= mem_rdata, tag set, valid=1, dirty=0. mem_read drops the next cycle. Go to COMPARE, which now hits.
- RESPOND: proc_ready=1 for exactly one cycle. Requests are ignored in this cycle because L1 still holds its request here. Go to IDLE.
- Hit latency: request high in cycle 0, proc_ready high in cycle 2.
- Clean read miss: proc_ready high 2 cycles after mem_ready.
- mem_ready arriving while not in WRITEBACK/ALLOCATE is ignored.
- Memory request signals are 0 whenever not in WRITEBACK/ALLOCATE.
- Counters stop at 16'hFFFF; they do not wrap.

Test Plan:
- Reset, then read 28'h0000010: clean miss → mem_read with mem_addr=28'h0000010. Return mem_rdata=128'hA5…A5 with mem_ready → proc_ready pulse, proc_rdata=128'hA5…A5; access_cnt=1, miss_cnt=1.
- Repeat the same read: no mem_read, proc_ready in cycle 2, same data; access_cnt=2, miss_cnt=1.
- Write 28'h0000050 (index 16, miss, clean victim) with data 128'h1234: no memory traffic, proc_ready pulse, dirty set. Then read 28'h0000010 (same index 16, different tag) → WRITEBACK mem_write, mem_addr=28'h0000050, mem_wdata=128'h1234, then ALLOCATE from 28'h0000010.
- Stretch mem_ready 20 cycles in ALLOCATE: mem_read and mem_addr stay stable for all 20 cycles; proc_ready stays 0; mem_read drops the cycle after mem_ready.
- Assert reset_n=0 mid-WRITEBACK: mem_write and proc_ready go to 0 asynchronously. After release, the earlier address misses again.
- Preload access_cnt near saturation via 65540 hits: access_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/l2_cache_if.sv
// Whole-line request/ready bus shared by the L1 side and the memory side of the L2.
interface l2_cache_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2: serves L1 line fills/writebacks, misses go to memory.
module l2_cache #(
  parameter int          INDEX_W = 6,
  parameter int          TAG_W   = 22,
  parameter int          LINE_W  = 128,
  parameter logic [15:0] CNT_SAT = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset_n,
  l2_cache_if.slave    proc,
  l2_cache_if.master   mem,
  output logic [15:0]  access_cnt,
  output logic [15:0]  miss_cnt
);
  localparam int LINES = 1 << INDEX_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COMPARE   = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_ALLOCATE  = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;

  logic [2:0]        state;
  logic [27:0]       req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              req_wr;
  logic              miss_seen;

  logic [LINES-1:0]  valid, dirty;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [LINE_W-1:0] lines [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit, victim_dirty;

  assign idx          = req_addr[INDEX_W-1:0];
  assign tag          = req_addr[27:INDEX_W];
  assign hit          = valid[idx] && (tags[idx] == tag);
  assign victim_dirty = valid[idx] && dirty[idx];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= CNT_SAT) ? v : v + 16'd1;
  endfunction

  // Line data has no reset; written on write hit, write install or fill.
  logic              line_we;
  logic [LINE_W-1:0] line_wd;
  always_comb begin
    line_we = 1'b0;
    line_wd = req_wdata;
    if (state == S_COMPARE && req_wr && (hit || !victim_dirty)) line_we = 1'b1;
    if (state == S_ALLOCATE && mem.ready) begin
      line_we = 1'b1;
      line_wd = mem.rdata;
    end
  end

  always_ff @(posedge clk) if (line_we) lines[idx] <= line_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_wr     <= 1'b0;
      miss_seen  <= 1'b0;
      valid      <= '0;
      dirty      <= '0;
      for (int i = 0; i < LINES; i++) tags[i] <= '0;
      proc.rdata <= '0;
      proc.ready <= 1'b0;
      mem.read   <= 1'b0;
      mem.write  <= 1'b0;
      mem.addr   <= '0;
      mem.wdata  <= '0;
      access_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (proc.read || proc.write) begin
          req_addr   <= proc.addr;
          req_wdata  <= proc.wdata;
          req_wr     <= proc.write;
          miss_seen  <= 1'b0;
          access_cnt <= sat_inc(access_cnt);
          state      <= S_COMPARE;
        end
        S_COMPARE: if (hit) begin
          if (req_wr) dirty[idx] <= 1'b1;
          else        proc.rdata <= lines[idx];
          proc.ready <= 1'b1;
          state      <= S_RESPOND;
        end else begin
          // A write re-entering after its writeback is still the same miss.
          if (!miss_seen) miss_cnt <= sat_inc(miss_cnt);
          miss_seen <= 1'b1;
          if (victim_dirty) begin
            mem.write <= 1'b1;
            mem.addr  <= {tags[idx], idx};
            mem.wdata <= lines[idx];
            state     <= S_WRITEBACK;
          end else if (!req_wr) begin
            mem.read <= 1'b1;
            mem.addr <= req_addr;
            state    <= S_ALLOCATE;
          end else begin
            tags[idx]  <= tag;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b1;
            proc.ready <= 1'b1;
            state      <= S_RESPOND;
          end
        end
        S_WRITEBACK: if (mem.ready) begin
          mem.write  <= 1'b0;
          mem.wdata  <= '0;
          dirty[idx] <= 1'b0;
          if (req_wr) begin
            mem.addr <= '0;
            state    <= S_COMPARE;
          end else begin
            mem.read <= 1'b1;
            mem.addr <= req_addr;
            state    <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: if (mem.ready) begin
          tags[idx]  <= tag;
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          mem.read   <= 1'b0;
          mem.addr   <= '0;
          state      <= S_COMPARE;
        end
        S_RESPOND: begin
          proc.ready <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_cache.sv
// Directed + randomized bench for l2_cache with a transaction-level cache/memory model.
module tb_l2_cache;
  localparam logic [15:0] SAT = 16'd200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] access_cnt, miss_cnt;

  l2_cache_if pif();
  l2_cache_if mif();

  l2_cache #(.INDEX_W(6), .TAG_W(22), .LINE_W(128), .CNT_SAT(SAT)) dut (
    .clk(clk), .reset_n(reset_n), .proc(pif), .mem(mif),
    .access_cnt(access_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: per-index line state plus a sparse backing memory.
  logic [127:0] tbmem [logic [27:0]];
  bit           m_valid [64];
  bit           m_dirty [64];
  logic [21:0]  m_tag   [64];
  logic [127:0] m_data  [64];
  int           exp_acc, exp_miss;

  int           l_cycles, l_nwb, l_nfetch;
  logic [27:0]  l_wb_addr, l_fetch_addr;
  logic [127:0] l_wb_data, l_rdata;
  bit           l_timeout, l_unstable, l_nodrop;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] memval(input logic [27:0] a);
    if (tbmem.exists(a)) return tbmem[a];
    return {4{4'hC, a}};
  endfunction

  function automatic int sat(input int v);
    return (v >= int'(SAT)) ? v : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    exp_acc = 0; exp_miss = 0;
  endtask

  // Drives one L1 request and plays the memory side until proc_ready.
  task automatic do_req(input bit wr, input logic [27:0] addr, input logic [127:0] wd, input int delay);
    int wait_cnt; bit busy, was_wr, ready_prev;
    logic [27:0] cur_addr; logic [127:0] cur_wdata;
    l_nwb = 0; l_nfetch = 0; l_timeout = 1; l_unstable = 0; l_nodrop = 0; l_cycles = -1;
    wait_cnt = 0; busy = 0; was_wr = 0; ready_prev = 0; cur_addr = '0; cur_wdata = '0;
    @(negedge clk);
    pif.write = wr;
    pif.read  = wr ? 1'($urandom_range(1)) : 1'b1;
    pif.addr  = addr;
    pif.wdata = wd;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      mif.ready = 1'b0;
      if (ready_prev) begin
        if (was_wr ? mif.write : mif.read) l_nodrop = 1;
        ready_prev = 0;
      end
      if (pif.ready) begin
        l_rdata = pif.rdata; l_cycles = c; l_timeout = 0;
        break;
      end
      if (mif.read || mif.write) begin
        if (!busy) begin
          busy = 1; wait_cnt = 0; was_wr = mif.write;
          cur_addr = mif.addr; cur_wdata = mif.wdata;
          if (mif.write) begin l_nwb++; l_wb_addr = mif.addr; l_wb_data = mif.wdata; end
          else begin l_nfetch++; l_fetch_addr = mif.addr; end
        end else if (mif.addr !== cur_addr || mif.write !== was_wr || mif.read !== !was_wr ||
                     (was_wr && mif.wdata !== cur_wdata)) l_unstable = 1;
        if (wait_cnt == delay) begin
          mif.ready = 1'b1;
          if (was_wr) tbmem[cur_addr] = cur_wdata;
          else        mif.rdata = memval(cur_addr);
          busy = 0; ready_prev = 1;
        end else wait_cnt++;
      end else if ($urandom_range(3) == 0) begin
        // stray mem_ready outside a memory transaction must be ignored
        mif.ready = 1'b1;
        mif.rdata = {4{$urandom}};
      end
    end
    pif.read = 1'b0; pif.write = 1'b0;
  endtask

  task automatic run_req(input bit wr, input logic [27:0] addr, input logic [127:0] wd, input int delay);
    logic [5:0] idx; logic [21:0] tag;
    bit hit, wb; logic [27:0] e_wb_addr; logic [127:0] e_wb_data, e_rdata; int e_cyc;
    idx = addr[5:0]; tag = addr[27:6];
    hit = m_valid[idx] && m_tag[idx] == tag;
    wb  = !hit && m_valid[idx] && m_dirty[idx];
    e_wb_addr = {m_tag[idx], idx}; e_wb_data = m_data[idx];
    exp_acc = sat(exp_acc);
    if (!hit) begin
      exp_miss = sat(exp_miss);
      m_valid[idx] = 1; m_tag[idx] = tag; m_dirty[idx] = 0;
      if (!wr) m_data[idx] = memval(addr);
    end
    if (wr) begin m_data[idx] = wd; m_dirty[idx] = 1; end
    e_rdata = m_data[idx];
    e_cyc = hit ? 2 : wr ? (wb ? 4 + delay : 2) : (wb ? 5 + 2 * delay : 4 + delay);
    do_req(wr, addr, wd, delay);
    check("timeout", l_timeout, 0);
    check("latency", l_cycles, e_cyc);
    check("wb_count", l_nwb, wb);
    if (wb) begin
      check("wb_addr", l_wb_addr, e_wb_addr);
      check("wb_data", l_wb_data, e_wb_data);
    end
    check("fetch_count", l_nfetch, !hit && !wr);
    if (!hit && !wr) check("fetch_addr", l_fetch_addr, addr);
    if (!wr) check("rdata", l_rdata, e_rdata);
    check("mem_stable", l_unstable, 0);
    check("mem_drop", l_nodrop, 0);
    check("access_cnt", access_cnt, exp_acc);
    check("miss_cnt", miss_cnt, exp_miss);
  endtask

  initial begin
    bit seen;
    pif.read = 0; pif.write = 0; pif.addr = '0; pif.wdata = '0;
    mif.ready = 0; mif.rdata = '0;
    model_reset();
    tbmem[28'h0000010] = {16{8'hA5}};
    repeat (3) @(negedge clk);
    check("rst_proc_ready", pif.ready, 0);
    check("rst_proc_rdata", pif.rdata, 0);
    check("rst_mem_req", {mif.read, mif.write}, 0);
    check("rst_mem_addr", mif.addr, 0);
    check("rst_mem_wdata", mif.wdata, 0);
    check("rst_counters", {access_cnt, miss_cnt}, 0);
    reset_n = 1'b1;

    run_req(0, 28'h0000010, '0, 3);
    check("t1_fetch_addr", l_fetch_addr, 28'h0000010);
    check("t1_rdata", l_rdata, {16{8'hA5}});
    check("t1_counts", {access_cnt, miss_cnt}, {16'd1, 16'd1});

    run_req(0, 28'h0000010, '0, 0);
    check("t2_no_fetch", l_nfetch, 0);
    check("t2_hit_latency", l_cycles, 2);
    check("t2_counts", {access_cnt, miss_cnt}, {16'd2, 16'd1});

    run_req(1, 28'h0000050, 128'h1234, 0);
    check("t3_no_mem", l_nwb + l_nfetch, 0);
    run_req(0, 28'h0000010, '0, 2);
    check("t3_wb_addr", l_wb_addr, 28'h0000050);
    check("t3_wb_data", l_wb_data, 128'h1234);
    check("t3_fetch_addr", l_fetch_addr, 28'h0000010);
    @(negedge clk);
    check("t3_rdata_held", pif.rdata, {16{8'hA5}});

    run_req(0, 28'h0000321, '0, 20);
    check("t4_stretch_latency", l_cycles, 24);
    check("t4_stretch_stable", l_unstable, 0);

    // reset in the middle of a writeback
    run_req(1, 28'h0000090, 128'hBEEF, 0);
    @(negedge clk);
    pif.read = 1'b1; pif.addr = 28'h0000010;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mif.write) begin seen = 1; break; end
    end
    check("t5_wb_started", seen, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_mem_write_async", mif.write, 0);
    check("t5_mem_addr_async", mif.addr, 0);
    check("t5_proc_ready_async", pif.ready, 0);
    check("t5_cnt_async", access_cnt, 0);
    pif.read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_req(0, 28'h0000010, '0, 1);
    check("t5_remiss", l_nfetch, 1);

    for (int n = 0; n < 100; n++)
      run_req(1'($urandom_range(1)), {22'($urandom_range(3)), 6'($urandom_range(7))},
              {$urandom, $urandom, $urandom, $urandom}, $urandom_range(3));

    for (int n = 0; n < 120; n++) run_req(0, 28'h0000010, '0, 0);
    check("sat_access_cnt", access_cnt, SAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
